// File: rtl/seq_control.sv
// seq_control: VeriRISC instruction sequencer.
// Eight-phase fetch/decode/execute FSM with a memory-ready stall and timeout
// fault, a sticky halt state with resume, single-step mode and a counter of
// retired instructions.
//
// Ports:
//   clk, rst_           clock (rising edge), async active-low reset
//   opcode[2:0]         current IR opcode (HLT=0 .. JMP=7)
//   zero                accumulator-zero flag
//   mem_ready           memory read data valid (looked at only while stalling)
//   step_en, step       single-step mode enable / advance pulse
//   resume              leave HALTED
//   mem_rd .. mem_wr    datapath controls (combinational from state + opcode)
//   fault               memory timeout fault
//   state_o[3:0]        current state encoding
//   retired[CNT_W-1:0]  completed instruction count (wraps)
module seq_control #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [2:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    input  logic             step_en,
    input  logic             step,
    input  logic             resume,
    output logic             mem_rd,
    output logic             load_ir,
    output logic             halt,
    output logic             inc_pc,
    output logic             load_ac,
    output logic             load_pc,
    output logic             mem_wr,
    output logic             fault,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        INST_ADDR  = 4'd0,
        INST_FETCH = 4'd1,
        INST_LOAD  = 4'd2,
        IDLE       = 4'd3,
        OP_ADDR    = 4'd4,
        OP_FETCH   = 4'd5,
        ALU_OP     = 4'd6,
        STORE      = 4'd7,
        HALTED     = 4'd8,
        FAULT      = 4'd9
    } state_t;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    // Stall counter only needs to reach TIMEOUT-1; the TIMEOUT-th stalled
    // edge goes to FAULT instead of incrementing.
    localparam int            WC_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              aluop;
    logic              stall;

    assign aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                   (opcode == OP_XOR) || (opcode == OP_LDA);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        retired_d  = retired_q;
        stall      = 1'b0;
        case (state_q)
            INST_ADDR:  if (!(step_en && !step)) state_d = INST_FETCH;
            INST_FETCH: if (mem_ready) state_d = INST_LOAD;
                        else           stall   = 1'b1;
            INST_LOAD:  state_d = IDLE;
            IDLE:       state_d = OP_ADDR;
            OP_ADDR:    state_d = (opcode == OP_HLT) ? HALTED : OP_FETCH;
            // Only ALU-class opcodes read an operand, so only they wait.
            OP_FETCH:   if (aluop && !mem_ready) stall   = 1'b1;
                        else                     state_d = ALU_OP;
            ALU_OP:     state_d = STORE;
            STORE: begin
                state_d   = INST_ADDR;
                retired_d = retired_q + 1'b1;
            end
            HALTED:     if (resume) state_d = INST_ADDR;
            FAULT:      state_d = FAULT;
            default:    state_d = INST_ADDR;
        endcase
        if (stall) begin
            if ((TIMEOUT > 0) && (wait_cnt_q == WC_LAST)) state_d = FAULT;
            else wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= INST_ADDR;
            wait_cnt_q <= '0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            retired_q  <= retired_d;
        end
    end

    // Controls decode straight from the registered state so they take
    // effect in the same cycle the state is entered.
    always_comb begin
        mem_rd  = 1'b0;
        load_ir = 1'b0;
        halt    = 1'b0;
        inc_pc  = 1'b0;
        load_ac = 1'b0;
        load_pc = 1'b0;
        mem_wr  = 1'b0;
        case (state_q)
            INST_FETCH: mem_rd = 1'b1;
            INST_LOAD, IDLE: begin
                mem_rd  = 1'b1;
                load_ir = 1'b1;
            end
            OP_ADDR: begin
                halt   = (opcode == OP_HLT);
                inc_pc = 1'b1;          // also for HLT: PC is past HLT on resume
            end
            OP_FETCH: mem_rd = aluop;
            ALU_OP: begin
                mem_rd  = aluop;
                inc_pc  = (opcode == OP_SKZ) && zero;
                load_ac = aluop;
                load_pc = (opcode == OP_JMP);
            end
            STORE: begin
                mem_rd  = aluop;
                inc_pc  = (opcode == OP_JMP);
                load_ac = aluop;
                load_pc = (opcode == OP_JMP);
                mem_wr  = (opcode == OP_STO);
            end
            HALTED:  halt = 1'b1;
            default: ;
        endcase
    end

    assign fault   = (state_q == FAULT);
    assign state_o = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_seq_control.sv
module tb_seq_control;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst_;
    logic [2:0]       opcode;
    logic             zero, mem_ready, step_en, step, resume;
    logic             mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, fault;
    logic [3:0]       state_o;
    logic [CNT_W-1:0] retired;

    seq_control #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .step_en(step_en), .step(step), .resume(resume),
        .mem_rd(mem_rd), .load_ir(load_ir), .halt(halt), .inc_pc(inc_pc),
        .load_ac(load_ac), .load_pc(load_pc), .mem_wr(mem_wr), .fault(fault),
        .state_o(state_o), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]       st;
        logic [7:0]       ctl;   // mem_rd load_ir halt inc_pc load_ac load_pc mem_wr fault
        logic [CNT_W-1:0] ret;
    } exp_t;

    exp_t             q[$];
    exp_t             mon_e;
    logic [7:0]       mon_ctl;
    int               n_chk  = 0;
    int               n_fail = 0;
    logic [3:0]       m_st;
    logic [CNT_W-1:0] ret_m;

    // Control expectations straight from the output table.
    function automatic logic [7:0] exp_ctl(input logic [3:0] st, input logic [2:0] op,
                                           input logic z);
        logic alu;
        alu = (op >= 3'd2) && (op <= 3'd5);
        case (st)
            4'd1:       return 8'b1000_0000;
            4'd2, 4'd3: return 8'b1100_0000;
            4'd4:       return {2'b00, op == 3'd0, 1'b1, 4'b0000};
            4'd5:       return {alu, 7'b0};
            4'd6:       return {alu, 2'b00, (op == 3'd1) && z, alu, op == 3'd7, 2'b00};
            4'd7:       return {alu, 2'b00, op == 3'd7, alu, op == 3'd7, op == 3'd6, 1'b0};
            4'd8:       return 8'b0010_0000;
            4'd9:       return 8'b0000_0001;
            default:    return 8'b0;
        endcase
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Monitor: every cycle that has an outstanding expectation is checked.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mon_e   = q.pop_front();
            mon_ctl = {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, fault};
            n_chk++;
            if (state_o !== mon_e.st || mon_ctl !== mon_e.ctl || retired !== mon_e.ret) begin
                n_fail++;
                $display("FAIL cycle t=%0t: got state=%0d ctl=%b ret=%0d, expected state=%0d ctl=%b ret=%0d",
                         $time, state_o, mon_ctl, retired, mon_e.st, mon_e.ctl, mon_e.ret);
            end
        end
    end

    // One clock edge: drive inputs, advance the reference model to the
    // state the sequencing rules dictate, queue the expectation.
    task automatic cyc(input logic mr, input logic se, input logic stp, input logic rs,
                       input logic [3:0] nst);
        exp_t e;
        @(negedge clk);
        mem_ready = mr; step_en = se; step = stp; resume = rs;
        if (m_st == 4'd7) ret_m = ret_m + 1'b1;
        m_st  = nst;
        e.st  = nst;
        e.ctl = exp_ctl(nst, opcode, zero);
        e.ret = ret_m;
        q.push_back(e);
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        #2 rst_ = 1'b0;
        #1;
        n_chk++;
        if (state_o !== 4'd0 || retired !== '0 ||
            {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, fault} !== 8'b0) begin
            n_fail++;
            $display("FAIL async_reset: got state=%0d ret=%0d ctl=%b, expected all zero",
                     state_o, retired,
                     {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, fault});
        end
        @(negedge clk);
        // Park in INST_ADDR for the first edge after release.
        step_en = 1'b1; step = 1'b0; resume = 1'b0; mem_ready = 1'b0;
        rst_  = 1'b1;
        m_st  = 4'd0;
        ret_m = '0;
        e.st  = 4'd0;
        e.ctl = exp_ctl(4'd0, opcode, zero);
        e.ret = '0;
        q.push_back(e);
    endtask

    // One whole instruction from INST_ADDR, with fs not-ready fetch edges and
    // os not-ready operand edges (os ignored for non-ALU opcodes).
    task automatic instr(input logic [2:0] op, input logic z, input int fs, input int os,
                         input logic se);
        logic alu;
        alu    = (op >= 3'd2) && (op <= 3'd5);
        opcode = op;
        zero   = z;
        cyc(rb(), se, se, rb(), 4'd1);
        for (int i = 0; i < fs; i++) cyc(1'b0, se, rb(), rb(), 4'd1);
        cyc(1'b1, se, rb(), rb(), 4'd2);
        cyc(rb(), se, rb(), rb(), 4'd3);
        cyc(rb(), se, rb(), rb(), 4'd4);
        if (op == 3'd0) begin
            cyc(rb(), se, rb(), rb(), 4'd8);
            return;
        end
        cyc(rb(), se, rb(), rb(), 4'd5);
        if (alu) begin
            for (int i = 0; i < os; i++) cyc(1'b0, se, rb(), rb(), 4'd5);
            cyc(1'b1, se, rb(), rb(), 4'd6);
        end else begin
            cyc(1'b0, se, rb(), rb(), 4'd6);
        end
        cyc(rb(), se, rb(), rb(), 4'd7);
        cyc(rb(), se, rb(), rb(), 4'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ = 1'b0; opcode = 3'd2; zero = 1'b0; mem_ready = 1'b0;
        step_en = 1'b0; step = 1'b0; resume = 1'b0;
        m_st = 4'd0; ret_m = '0;
        do_reset();

        // Directed opcodes with full readiness.
        instr(3'd2, 1'b0, 0, 0, 1'b0);   // ADD
        instr(3'd1, 1'b1, 0, 0, 1'b0);   // SKZ, zero set
        instr(3'd7, 1'b0, 0, 0, 1'b0);   // JMP
        instr(3'd6, 1'b0, 0, 0, 1'b0);   // STO, operand fetch ignores not-ready

        // Random instructions with stalls up to TIMEOUT-1 (ready wins on the
        // TIMEOUT-th edge); enough of them to wrap the 4-bit counter.
        for (int n = 0; n < 20; n++)
            instr(3'($urandom_range(1, 7)), rb(), $urandom_range(0, TIMEOUT - 1),
                  $urandom_range(0, TIMEOUT - 1), 1'b0);

        // HLT: hold in HALTED, then resume together with a step request.
        instr(3'd0, rb(), 1, 0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(rb(), rb(), rb(), 1'b0, 4'd8);
        cyc(rb(), 1'b1, 1'b1, 1'b1, 4'd0);
        instr(3'd2, rb(), 0, 1, 1'b1);   // step still high: advances from INST_ADDR

        // Single-step: hold, one pulse = one instruction, then drop step_en.
        for (int i = 0; i < 5; i++) cyc(rb(), 1'b1, 1'b0, rb(), 4'd0);
        instr(3'd4, rb(), 2, 0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(rb(), 1'b1, 1'b0, rb(), 4'd0);
        instr(3'd5, rb(), 0, 2, 1'b0);

        // Timeout in INST_FETCH: exactly TIMEOUT not-ready edges, then sticky.
        opcode = 3'd2;
        cyc(rb(), 1'b0, 1'b0, rb(), 4'd1);
        for (int i = 0; i < TIMEOUT - 1; i++) cyc(1'b0, 1'b0, rb(), rb(), 4'd1);
        cyc(1'b0, 1'b0, rb(), rb(), 4'd9);
        for (int i = 0; i < 4; i++) cyc(rb(), rb(), rb(), 1'b1, 4'd9);
        do_reset();

        // Timeout in OP_FETCH for an ALU opcode.
        opcode = 3'd4; zero = 1'b0;
        cyc(rb(), 1'b0, 1'b0, rb(), 4'd1);
        cyc(1'b1, 1'b0, rb(), rb(), 4'd2);
        cyc(rb(), 1'b0, rb(), rb(), 4'd3);
        cyc(rb(), 1'b0, rb(), rb(), 4'd4);
        cyc(rb(), 1'b0, rb(), rb(), 4'd5);
        for (int i = 0; i < TIMEOUT - 1; i++) cyc(1'b0, 1'b0, rb(), rb(), 4'd5);
        cyc(1'b0, 1'b0, rb(), rb(), 4'd9);
        cyc(1'b1, 1'b0, rb(), rb(), 4'd9);
        do_reset();

        // Retire one, then reset asynchronously in the middle of a fetch stall.
        instr(3'd3, 1'b0, 0, 0, 1'b0);
        cyc(rb(), 1'b0, 1'b0, rb(), 4'd1);
        cyc(1'b0, 1'b0, rb(), rb(), 4'd1);
        cyc(1'b0, 1'b0, rb(), rb(), 4'd1);
        do_reset();
        instr(3'd2, 1'b0, 0, 0, 1'b0);

        repeat (3) @(negedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
